apb_initiator: RTL

- Single-outstanding APB3 master. Converts a valid/ready request interface (from a CPU-less sequencer, DMA or debug bridge) into APB3 SETUP/ACCESS transfers toward peripherals such as the fabric UART.
- Honours PREADY wait states and captures PSLVERR.
- Aborts hung transfers with a programmable timeout and returns one response per request.

---
 rtl/apb_initiator.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/apb_initiator.sv
// Single-outstanding APB3 master: turns a valid/ready request into one
// SETUP/ACCESS transfer and returns exactly one held response per request.
module apb_initiator #(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int unsigned CNT_W = 16;
    // Counter value of the last tolerated ACCESS cycle; unused when timeout is off.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_d;
    logic               psel_d;
    logic               penable_d;
    logic               pwrite_d;
    logic [ADDR_W-1:0]  paddr_d;
    logic [DATA_W-1:0]  pwdata_d;
    logic               rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_d;
    logic               rsp_err_d;
    logic               rsp_timeout_d;
    logic               busy_d;

    // Only the request handshake is combinational: accept whenever idle.
    assign req_ready = (state == IDLE);

    // State, APB outputs, response and wait counter registers.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_d;
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            PWRITE      <= pwrite_d;
            PADDR       <= paddr_d;
            PWDATA      <= pwdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            busy        <= busy_d;
        end
    end

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_next    = state;
        wait_cnt_d    = wait_cnt;
        psel_d        = PSEL;
        penable_d     = PENABLE;
        pwrite_d      = PWRITE;
        paddr_d       = PADDR;
        pwdata_d      = PWDATA;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    pwrite_d   = req_write;
                    paddr_d    = req_addr;
                    pwdata_d   = req_wdata;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_next = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_d   = PWRITE ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_next    = RESP;
                end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_next    = RESP;
                end else if (wait_cnt != CNT_MAX) begin
                    // Saturate so a disabled timeout never wraps back to CNT_LAST.
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_d = (state_next != IDLE);
    end

endmodule
